// File: rtl/cirno9_sram_arb.sv
// Arbitrates IFU fetches and LSU loads/stores onto one single-port SRAM; grant and command are combinational.
// Read data returns one cycle after grant; a loser simply keeps its request held (no queueing).
module cirno9_sram_arb #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_adr,
  output logic        ifu_gnt,
  output logic        ifu_rvld,
  output logic [31:0] ifu_rdat,
  input  logic        lsu_req,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_adr,
  input  logic [31:0] lsu_wdat,
  output logic        lsu_gnt,
  output logic        lsu_rvld,
  output logic [31:0] lsu_rdat,
  output logic        sram_ren,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_adr,
  output logic [31:0] sram_wdat,
  input  logic [31:0] sram_rdat
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IFU  = 2'd1;
  localparam logic [1:0] OWN_LSU  = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic [1:0] owner;
  logic       ifu_starved;

  assign ifu_starved = (starve_cnt == STARVE_LIM);

  // LSU wins ties until the IFU has been passed over STARVE_MAX times in a row.
  always_comb begin
    lsu_gnt = 1'b0;
    ifu_gnt = 1'b0;
    if (!rst) begin
      lsu_gnt = lsu_req && !(ifu_req && ifu_starved);
      ifu_gnt = ifu_req && !lsu_gnt;
    end
  end

  always_comb begin
    sram_ren  = 1'b0;
    sram_wen  = 4'h0;
    sram_adr  = 32'h0;
    sram_wdat = 32'h0;
    if (lsu_gnt) begin
      sram_ren  = (lsu_we == 4'h0);
      sram_wen  = lsu_we;
      sram_adr  = lsu_adr;
      sram_wdat = lsu_wdat;
    end else if (ifu_gnt) begin
      sram_ren  = 1'b1;
      sram_adr  = ifu_adr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'h0;
    end else if (ifu_gnt || !ifu_req) begin
      starve_cnt <= 4'h0;
    end else if (lsu_gnt && !ifu_starved) begin
      starve_cnt <= starve_cnt + 4'h1;
    end
  end

  // Stores finish at grant, so only reads claim the return slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_NONE;
    end else if (ifu_gnt) begin
      owner <= OWN_IFU;
    end else if (lsu_gnt && (lsu_we == 4'h0)) begin
      owner <= OWN_LSU;
    end else begin
      owner <= OWN_NONE;
    end
  end

  assign ifu_rvld = (owner == OWN_IFU);
  assign lsu_rvld = (owner == OWN_LSU);
  assign ifu_rdat = ifu_rvld ? sram_rdat : 32'h0;
  assign lsu_rdat = lsu_rvld ? sram_rdat : 32'h0;

endmodule
